// File: rtl/bcd_count_display_pkg.sv
// Shared constants for the trigger path: default digit count, scan prescaler
// width and the BCD to 7-segment table ({g,f,e,d,c,b,a}, active-high).
package bcd_count_display_pkg;

    localparam int unsigned DigitsDefault   = 6;
    localparam int unsigned ScanBitsDefault = 10;

    // Codes 10..15 never occur in a BCD digit; they blank the display.
    localparam logic [6:0] SegTable [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00
    };

endpackage

// File: rtl/bcd_count_display_if.sv
// Trigger inputs and display outputs of the counter/display block.
interface bcd_count_display_if
    import bcd_count_display_pkg::*;
#(
    parameter int unsigned DIGITS = DigitsDefault
);
    logic              inc_clk;
    logic              ref_clk;
    logic [DIGITS-1:0] trigger;
    logic [6:0]        seg;
    logic [DIGITS-1:0] dig_en;
    logic              busy;
    logic              overflow;

    modport master (
        output inc_clk, ref_clk, trigger,
        input  seg, dig_en, busy, overflow
    );

    modport slave (
        input  inc_clk, ref_clk, trigger,
        output seg, dig_en, busy, overflow
    );
endinterface

// File: rtl/bcd_count_display_bcd_to_7seg.sv
// Purely combinational BCD digit to 7-segment decode.
module bcd_to_7seg
    import bcd_count_display_pkg::*;
(
    input  logic [3:0] bcd_i,
    output logic [6:0] seg_o
);
    assign seg_o = SegTable[bcd_i];
endmodule

// File: rtl/bcd_count_display.sv
// BCD event counter with one-level-per-cycle carry ripple, refresh snapshot
// and a time-multiplexed 7-segment scan of the snapshot.
module bcd_count_display
    import bcd_count_display_pkg::*;
#(
    parameter int unsigned DIGITS    = DigitsDefault,
    parameter int unsigned SCAN_BITS = ScanBitsDefault
) (
    input logic               clk,
    input logic               reset,
    bcd_count_display_if.slave bus
);
    localparam int unsigned IdxW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic [DIGITS-1:0][3:0] count_q, count_d;
    logic [DIGITS-1:0][3:0] disp_q;
    logic [DIGITS-1:0]      carry_q, carry_d;
    logic [DIGITS-1:0]      wrap;
    logic                   overflow_q;
    logic [SCAN_BITS-1:0]   presc_q;
    logic [IdxW-1:0]        idx_q;
    logic                   busy;
    logic [6:0]             seg;

    assign busy = |carry_q;

    // While busy only the carry drives increments; new pulses are dropped.
    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        logic bump;
        assign bump       = busy ? carry_q[i] : (bus.inc_clk & bus.trigger[i]);
        assign wrap[i]    = bump && (count_q[i] == 4'd9);
        assign count_d[i] = !bump   ? count_q[i] :
                            wrap[i] ? 4'd0       : count_q[i] + 4'd1;
    end

    // The top digit's wrap falls off the end and only feeds overflow.
    assign carry_d = wrap << 1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q    <= '0;
            carry_q    <= '0;
            disp_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            carry_q    <= carry_d;
            overflow_q <= overflow_q | wrap[DIGITS-1];
            if (bus.ref_clk) begin
                disp_q <= count_q;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc_q <= '0;
            idx_q   <= '0;
        end else begin
            presc_q <= presc_q + SCAN_BITS'(1);
            if (presc_q == '1) begin
                idx_q <= (idx_q == IdxW'(DIGITS - 1)) ? '0 : idx_q + IdxW'(1);
            end
        end
    end

    bcd_to_7seg u_bcd_to_7seg (
        .bcd_i (disp_q[idx_q]),
        .seg_o (seg)
    );

    assign bus.seg      = seg;
    assign bus.dig_en   = DIGITS'(1) << idx_q;
    assign bus.busy     = busy;
    assign bus.overflow = overflow_q;
endmodule

// File: tb/tb_bcd_count_display.sv
// Scoreboard bench: expected display snapshots are queued at each refresh and
// compared when the scan has presented every digit.
module tb_bcd_count_display;
    localparam int unsigned Digits   = 6;
    localparam int unsigned ScanBits = 2;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    bcd_count_display_if #(.DIGITS(Digits)) bus ();

    bcd_count_display #(
        .DIGITS    (Digits),
        .SCAN_BITS (ScanBits)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned model_cnt = 0;
    bit          model_ovf = 1'b0;
    int unsigned exp_q[$];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int unsigned seg2dig(input logic [6:0] s);
        case (s)
            7'h3F: return 0;
            7'h06: return 1;
            7'h5B: return 2;
            7'h4F: return 3;
            7'h66: return 4;
            7'h6D: return 5;
            7'h7D: return 6;
            7'h07: return 7;
            7'h7F: return 8;
            7'h6F: return 9;
            default: return 15;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void model_add(input logic [Digits-1:0] mask);
        int unsigned add = 0;
        int unsigned p   = 1;
        for (int i = 0; i < Digits; i++) begin
            if (mask[i]) add += p;
            p *= 10;
        end
        model_cnt += add;
        if (model_cnt >= 1000000) begin
            model_cnt -= 1000000;
            model_ovf = 1'b1;
        end
    endfunction

    task automatic pulse_inc(input logic [Digits-1:0] mask);
        bus.trigger = mask;
        bus.inc_clk = 1'b1;
        tick();
        bus.inc_clk = 1'b0;
        bus.trigger = '0;
        model_add(mask);
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 20 && bus.busy; k++) tick();
        check_eq("idle_bound", 32'(bus.busy), 32'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        model_cnt = 0;
        model_ovf = 1'b0;
    endtask

    task automatic preload(input int unsigned val);
        int unsigned v = val;
        do_reset();
        for (int i = 0; i < Digits; i++) begin
            repeat (v % 10) pulse_inc(Digits'(1) << i);
            v /= 10;
        end
    endtask

    task automatic refresh();
        exp_q.push_back(model_cnt);
        bus.ref_clk = 1'b1;
        tick();
        bus.ref_clk = 1'b0;
    endtask

    // Walk the scan through all digits and rebuild the snapshot from seg.
    task automatic read_disp(input string tag);
        int unsigned got = 0;
        int unsigned p   = 1;
        int unsigned exp;
        exp = exp_q.pop_front();
        for (int i = 0; i < Digits; i++) begin
            for (int k = 0; k < 40 && bus.dig_en != (Digits'(1) << i); k++) tick();
            if (bus.dig_en != (Digits'(1) << i)) begin
                check_eq({tag, "_scan_bound"}, 32'(bus.dig_en), 32'(Digits'(1) << i));
                got += 15 * p;
            end else begin
                got += seg2dig(bus.seg) * p;
            end
            p *= 10;
        end
        check_eq(tag, got, exp);
    endtask

    initial begin
        bus.inc_clk = 1'b0;
        bus.ref_clk = 1'b0;
        bus.trigger = '0;
        reset = 1'b1;
        tick();
        tick();
        check_eq("rst_seg", 32'(bus.seg), 32'h3F);
        check_eq("rst_dig_en", 32'(bus.dig_en), 32'd1);
        check_eq("rst_busy", 32'(bus.busy), 32'd0);
        check_eq("rst_ovf", 32'(bus.overflow), 32'd0);
        reset = 1'b0;

        // Single increments, the tenth carries for exactly one cycle.
        pulse_inc(6'b000001);
        repeat (16) tick();
        refresh();
        read_disp("inc_one");
        for (int n = 2; n <= 10; n++) begin
            pulse_inc(6'b000001);
            check_eq("inc_busy_e0", 32'(bus.busy), (n == 10) ? 32'd1 : 32'd0);
            tick();
            check_eq("inc_busy_e1", 32'(bus.busy), 32'd0);
            repeat (16) tick();
        end
        refresh();
        read_disp("inc_ten");

        // Full ripple 099999 + 1.
        preload(99999);
        pulse_inc(6'b000001);
        for (int k = 0; k < 5; k++) begin
            check_eq("ripple_busy", 32'(bus.busy), 32'd1);
            tick();
        end
        check_eq("ripple_done", 32'(bus.busy), 32'd0);
        check_eq("ripple_ovf", 32'(bus.overflow), 32'd0);
        refresh();
        read_disp("ripple_val");

        // 999999 + 1 wraps and sets sticky overflow at E0+5.
        preload(999999);
        pulse_inc(6'b000001);
        repeat (4) tick();
        check_eq("ovf_e4", 32'(bus.overflow), 32'd0);
        tick();
        check_eq("ovf_e5", 32'(bus.overflow), 32'(model_ovf));
        check_eq("ovf_busy", 32'(bus.busy), 32'd0);
        repeat (10) tick();
        check_eq("ovf_sticky", 32'(bus.overflow), 32'(model_ovf));
        refresh();
        read_disp("ovf_val");

        // Two masked digits each start their own carry.
        preload(909);
        pulse_inc(6'b000101);
        wait_idle();
        refresh();
        read_disp("multi_mask");

        // Increment while busy is dropped.
        preload(9);
        pulse_inc(6'b000001);
        bus.inc_clk = 1'b1;
        bus.trigger = 6'b000001;
        tick();
        bus.inc_clk = 1'b0;
        bus.trigger = '0;
        wait_idle();
        refresh();
        read_disp("inc_while_busy");

        // Simultaneous increment and refresh snapshots the old count.
        exp_q.push_back(model_cnt);
        bus.inc_clk = 1'b1;
        bus.trigger = 6'b000001;
        bus.ref_clk = 1'b1;
        tick();
        bus.inc_clk = 1'b0;
        bus.trigger = '0;
        bus.ref_clk = 1'b0;
        model_add(6'b000001);
        read_disp("inc_and_ref");
        refresh();
        read_disp("after_inc_ref");

        // Empty mask.
        pulse_inc(6'b000000);
        check_eq("mask0_busy", 32'(bus.busy), 32'd0);
        refresh();
        read_disp("mask0_val");

        // Reset mid-ripple, then scan cadence from reset release.
        preload(99999);
        pulse_inc(6'b000001);
        tick();
        reset = 1'b1;
        #1;
        check_eq("midrst_seg", 32'(bus.seg), 32'h3F);
        check_eq("midrst_dig_en", 32'(bus.dig_en), 32'd1);
        check_eq("midrst_busy", 32'(bus.busy), 32'd0);
        check_eq("midrst_ovf", 32'(bus.overflow), 32'd0);
        tick();
        reset = 1'b0;
        model_cnt = 0;
        model_ovf = 1'b0;
        for (int k = 1; k <= 28; k++) begin
            tick();
            check_eq("scan_idx", 32'(bus.dig_en), 32'(Digits'(1) << ((k / 4) % Digits)));
        end

        // Scan of 123456 shows 6,5,4,3,2,1 on idx 0..5.
        preload(123456);
        refresh();
        read_disp("scan_123456");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
